// File: rtl/async_seq_checker.sv
// Synchronises and deglitches a 4-bit ripple-counter bus, then checks each settled value
// against the legal next-state table. Optional history port enabled by SEQ_CHK_HIST_EN.
module async_seq_checker #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 3,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       q_in,
    input  logic             clr_err,
    output logic [3:0]       seq_val,
    output logic             val_valid,
    output logic             locked,
    output logic             err,
    output logic             err_sticky,
    output logic [ERR_W-1:0] err_count
`ifdef SEQ_CHK_HIST_EN
    ,
    output logic [15:0]      hist
`endif
);

    localparam int SCW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [SCW-1:0] SC_MAX = SCW'(STABLE_CYCLES - 1);

    typedef enum logic {SEEK, TRACK} state_t;

    logic [3:0]     sync_q [SYNC_STAGES];
    logic [3:0]     s_q;
    logic [3:0]     cand;
    logic [SCW-1:0] scnt;
    logic           seen;
    logic           acc;
    state_t         state, state_nxt;
    logic [3:0]     exp_val, exp_nxt;
    logic           err_nxt;
    logic [4:0]     lk;

    // Returns {legal, next value} for the ripple counter sequence.
    function automatic logic [4:0] nxt_lookup(input logic [3:0] v);
        case (v)
            4'd0:    nxt_lookup = {1'b1, 4'd2};
            4'd2:    nxt_lookup = {1'b1, 4'd5};
            4'd5:    nxt_lookup = {1'b1, 4'd7};
            4'd7:    nxt_lookup = {1'b1, 4'd8};
            4'd8:    nxt_lookup = {1'b1, 4'd10};
            4'd10:   nxt_lookup = {1'b1, 4'd9};
            4'd9:    nxt_lookup = {1'b1, 4'd11};
            4'd11:   nxt_lookup = {1'b1, 4'd8};
            default: nxt_lookup = {1'b0, 4'd0};
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 4'd0;
        end else begin
            sync_q[0] <= q_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign s_q = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            cand <= 4'd0;
            scnt <= '0;
        end else if (s_q != cand) begin
            cand <= s_q;
            scnt <= '0;
        end else if (scnt != SC_MAX) begin
            scnt <= scnt + 1'b1;
        end
    end

    // seen forces the very first settled value through even when it equals the reset seq_val.
    assign acc = (scnt == SC_MAX) && ((cand != seq_val) || !seen);
    assign lk  = nxt_lookup(cand);

    always_comb begin
        state_nxt = state;
        exp_nxt   = exp_val;
        err_nxt   = 1'b0;
        if (acc) begin
            case (state)
                SEEK: begin
                    if (lk[4]) begin
                        state_nxt = TRACK;
                        exp_nxt   = lk[3:0];
                    end
                end
                TRACK: begin
                    if (cand != exp_val) err_nxt = 1'b1;
                    if (lk[4]) exp_nxt = lk[3:0];
                    else       state_nxt = SEEK;
                end
                default: state_nxt = SEEK;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= SEEK;
            exp_val <= 4'd0;
        end else begin
            state   <= state_nxt;
            exp_val <= exp_nxt;
        end
    end

    assign locked = (state == TRACK);

    always_ff @(posedge clk) begin
        if (rst) begin
            seq_val   <= 4'd0;
            val_valid <= 1'b0;
            seen      <= 1'b0;
            err       <= 1'b0;
        end else begin
            val_valid <= acc;
            err       <= err_nxt;
            if (acc) begin
                seq_val <= cand;
                seen    <= 1'b1;
            end
        end
    end

    // A clear wins over a coincident mismatch; the err pulse itself is unaffected.
    always_ff @(posedge clk) begin
        if (rst || clr_err) begin
            err_sticky <= 1'b0;
            err_count  <= '0;
        end else if (err_nxt) begin
            err_sticky <= 1'b1;
            if (err_count != {ERR_W{1'b1}}) err_count <= err_count + 1'b1;
        end
    end

`ifdef SEQ_CHK_HIST_EN
    always_ff @(posedge clk) begin
        if (rst)      hist <= 16'd0;
        else if (acc) hist <= {hist[11:0], cand};
    end
`endif

endmodule
